// File: rtl/iir_inverse_pkg.sv
// Shared types, default parameter values and width helpers for iir_inverse.
package iir_inverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int N_DEF    = 4;
  localparam int CW_DEF   = 16;
  localparam int XW_DEF   = 32;
  localparam int YW_DEF   = 12;
  localparam int FRAC_DEF = 6;

  // Accumulator wide enough that x<<<FRAC minus N products never overflows.
  function automatic int acc_width(input int xw, input int cw, input int n);
    return xw + cw + $clog2(n) + 1;
  endfunction

  // Coefficient address width; at least one bit even for a single tap.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iir_inverse_if.sv
// Sample, result and coefficient-write signals of iir_inverse.
interface iir_inverse_if
  import iir_inverse_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF,
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
);
  localparam int ADW = addr_width(N);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [XW-1:0]  x;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [YW-1:0]  y;
  logic                  coef_we;
  logic [ADW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  busy;

  modport master (
    output in_valid, x, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, x, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, y, busy
  );

endinterface

// File: rtl/iir_mac_unit.sv
// Signed multiply-subtract with a registered accumulator.
module iir_mac_unit
  import iir_inverse_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int YW = YW_DEF,
  parameter int AW = acc_width(XW_DEF, CW_DEF, N_DEF)
)(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 load,
  input  logic                 sub_en,
  input  logic signed [AW-1:0] load_val,
  input  logic signed [CW-1:0] coef,
  input  logic signed [YW-1:0] sample,
  output logic signed [AW-1:0] acc
);

  logic signed [CW+YW-1:0] prod;
  logic signed [AW-1:0]    acc_q, acc_d;

  assign prod = (CW+YW)'(coef) * (CW+YW)'(sample);
  assign acc  = acc_q;

  // Next accumulator: load a fresh sample or subtract one product.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (sub_en) begin
      acc_d = acc_q - AW'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_inverse.sv
// Inverse IIR: y[n] = (x[n]*2^FRAC - sum a[k]*y[n-k]) >>> FRAC, one tap per cycle.
// Optional macro IIR_INVERSE_SAT_EN: clamp the narrowed output instead of wrapping.
module iir_inverse
  import iir_inverse_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int CW   = CW_DEF,
  parameter int XW   = XW_DEF,
  parameter int YW   = YW_DEF,
  parameter int FRAC = FRAC_DEF
)(
  input logic         clk,
  input logic         nreset,
  iir_inverse_if.slave bus
);

  localparam int AW  = acc_width(XW, CW, N);
  localparam int ADW = addr_width(N);
  localparam int KW  = $clog2(N + 1);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [YW-1:0] y_q, y_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [YW-1:0] hist_q [N];
  logic signed [YW-1:0] hist_d [N];
  logic signed [CW-1:0] coef_q [N];
  logic signed [CW-1:0] coef_d [N];

  logic                 mac_load, mac_sub;
  logic signed [AW-1:0] x_ext, acc;
  logic signed [CW-1:0] coef_sel;
  logic signed [YW-1:0] hist_sel;

`ifdef IIR_INVERSE_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (YW - 1)) - 1);
  localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** (YW - 1)));
`endif

  // Floor-shift the accumulator and narrow it to the output width.
  function automatic logic signed [YW-1:0] narrow(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> FRAC;
`ifdef IIR_INVERSE_SAT_EN
    if (s > Y_MAX) begin
      s = Y_MAX;
    end else if (s < Y_MIN) begin
      s = Y_MIN;
    end
`else
`endif
    return $signed(s[YW-1:0]);
  endfunction

  assign x_ext         = AW'(bus.x) <<< FRAC;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

  // Select coefficient a[k+1] and history y[n-k-1] for the current MAC step.
  always_comb begin
    coef_sel = '0;
    hist_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        coef_sel = coef_q[i];
        hist_sel = hist_q[i];
      end
    end
  end

  iir_mac_unit #(
    .CW (CW),
    .YW (YW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .nreset   (nreset),
    .load     (mac_load),
    .sub_en   (mac_sub),
    .load_val (x_ext),
    .coef     (coef_sel),
    .sample   (hist_sel),
    .acc      (acc)
  );

  // Control: accept in IDLE, N subtract steps plus one narrowing step in MAC,
  // hold the result in OUT until consumed, then shift the history.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    mac_load    = 1'b0;
    mac_sub     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.coef_we) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (bus.coef_addr == ADW'(i)) begin
              coef_d[i] = bus.coef_data;
            end
          end
        end
        if (bus.in_valid) begin
          mac_load = 1'b1;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        if (k_q == KW'(N)) begin
          y_d         = narrow(acc);
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          mac_sub = 1'b1;
          k_d     = k_q + KW'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          hist_d[0] = y_q;
          for (int unsigned i = 1; i < N; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result, history and coefficient registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      hist_q      <= '{default: '0};
      coef_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
    end
  end

endmodule

// File: tb/tb_iir_inverse.sv
// Self-checking bench for iir_inverse against an arithmetic recurrence model.
module tb_iir_inverse;

  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int XW   = 32;
  localparam int YW   = 12;
  localparam int FRAC = 6;
  localparam int ADW  = (N > 1) ? $clog2(N) : 1;

  logic clk    = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  iir_inverse_if #(.N(N), .CW(CW), .XW(XW), .YW(YW)) bus ();

  iir_inverse #(.N(N), .CW(CW), .XW(XW), .YW(YW), .FRAC(FRAC)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: coefficients a[1..N] and past outputs (mh[0] = y[n-1]).
  longint ma [N+1];
  longint mh [N];

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint narrow_ref(input longint v);
    longint lim;
    longint w;
    lim = longint'(1) << (YW - 1);
`ifdef IIR_INVERSE_SAT_EN
    w = v;
    if (w > lim - 1) w = lim - 1;
    if (w < -lim) w = -lim;
`else
    w = ((v % (2 * lim)) + 2 * lim) % (2 * lim);
    if (w >= lim) w = w - 2 * lim;
`endif
    return w;
  endfunction

  function automatic longint model_y(input longint xv);
    longint scale;
    longint s;
    scale = longint'(1) << FRAC;
    s = xv * scale;
    for (int k = 1; k <= N; k++) s = s - ma[k] * mh[k-1];
    return narrow_ref(floor_div(s, scale));
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= N; k++) ma[k] = 0;
    for (int k = 0; k < N; k++) mh[k] = 0;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.in_ready) check(tag, bus.in_ready, 1);
  endtask

  task automatic do_reset();
    #2 nreset = 1'b0;
    #4 nreset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int k, input longint v);
    wait_ready("coef_ready_timeout");
    bus.coef_we   = 1'b1;
    bus.coef_addr = ADW'(k - 1);
    bus.coef_data = CW'(v);
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
    ma[k] = v;
  endtask

  // One sample end to end; optional same-cycle coefficient write, ignored
  // write during MAC, and a stall of 'stall' cycles with out_ready low.
  task automatic run_sample(input longint xv, input bit we, input int wk, input longint wv,
                            input bit mac_we, input int stall, output longint got);
    longint want;
    int cyc;
    wait_ready("in_ready_timeout");
    bus.in_valid = 1'b1;
    bus.x        = XW'(xv);
    if (we) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = ADW'(wk - 1);
      bus.coef_data = CW'(wv);
      ma[wk] = wv;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    want = model_y(xv);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      if (cyc == 0) begin
        check("busy_mac", bus.busy, 1);
        check("in_ready_mac", bus.in_ready, 0);
      end
      if (mac_we) begin
        bus.coef_we   = (cyc < 2);
        bus.coef_addr = '0;
        bus.coef_data = CW'(50);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.coef_we = 1'b0;
    check("latency", cyc, N + 1);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = XW'(777);
      @(posedge clk); #1;
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_y", bus.y, want);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    got = bus.y;
    check("y", got, want);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    for (int k = N - 1; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = want;
  endtask

  initial begin
    longint got;
    longint imp [8];
    longint big_want;
    imp = '{64, 32, 16, 8, 4, 2, 1, 0};
`ifdef IIR_INVERSE_SAT_EN
    big_want = 2047;
`else
    big_want = 904;
`endif
    drive_idle();
    model_reset();

    // Reset values, while asserted and after release.
    #2 nreset = 1'b0;
    #8;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    #3 nreset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);

    // Pass-through with reset coefficients.
    run_sample(100, 0, 1, 0, 0, 0, got);
    check("pass_100", got, 100);

    // Decaying impulse response with a[1] = -32.
    do_reset();
    write_coef(1, -32);
    for (int i = 0; i < 8; i++) begin
      run_sample((i == 0) ? 64 : 0, 0, 1, 0, 0, 0, got);
      check($sformatf("impulse_%0d", i), got, imp[i]);
    end

    // Output stalled for 10 cycles with a competing input pending.
    run_sample(37, 0, 1, 0, 0, 10, got);
    run_sample(-12, 0, 1, 0, 0, 0, got);

    // Coefficient write during MAC must be dropped.
    run_sample(-200, 0, 1, 0, 1, 0, got);
    run_sample(300, 0, 1, 0, 0, 0, got);

    // Narrowing of out-of-range results.
    do_reset();
    run_sample(5000, 0, 1, 0, 0, 0, got);
    check("big_pos", got, big_want);
    run_sample(-5000, 0, 1, 0, 0, 0, got);

    // Reset in the middle of MAC.
    write_coef(1, -32);
    wait_ready("abort_ready_timeout");
    bus.in_valid = 1'b1;
    bus.x        = XW'(64);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    #2 nreset = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_y", bus.y, 0);
    check("abort_busy", bus.busy, 0);
    #3 nreset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("abort_in_ready", bus.in_ready, 1);
    run_sample(64, 0, 1, 0, 0, 0, got);
    check("abort_imp0", got, 64);
    run_sample(0, 0, 1, 0, 0, 0, got);
    check("abort_imp1_no_coef", got, 0);
    write_coef(1, -32);
    for (int i = 0; i < 8; i++) begin
      run_sample((i == 0) ? 64 : 0, 0, 1, 0, 0, 0, got);
      check($sformatf("reimpulse_%0d", i), got, imp[i]);
    end

    // Randomized coefficients, samples, same-cycle writes and stalls.
    do_reset();
    for (int k = 1; k <= N; k++) write_coef(k, longint'($urandom_range(0, 24)) - 12);
    for (int i = 0; i < 40; i++) begin
      longint xv;
      bit we;
      if ($urandom_range(0, 7) == 0) xv = longint'(int'($urandom()));
      else xv = longint'($urandom_range(0, 6000)) - 3000;
      we = ($urandom_range(0, 4) == 0);
      run_sample(xv, we, int'($urandom_range(1, N)), longint'($urandom_range(0, 24)) - 12,
                 ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", n_checks, -1);
    $fatal(1, "timeout");
  end

endmodule
